// File: rtl/imem_responder.sv
// Instruction memory responder: word-addressed synchronous RAM behind a
// valid/ready request port, returning in-order responses through a 2-entry FIFO.
module imem_responder #(
    parameter int unsigned      XLEN      = 32,
    parameter logic [XLEN-1:0]  BASE_ADDR = 32'h1000_0000,
    parameter logic [XLEN-1:0]  MAX_ADDR  = 32'h1000_3FFF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [XLEN-1:0] req_addr,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_data,
    output logic            rsp_err,
    input  logic            wr_en,
    input  logic [XLEN-1:0] wr_addr,
    input  logic [XLEN-1:0] wr_data
);

    localparam int unsigned DEPTH = 32'((MAX_ADDR - BASE_ADDR + XLEN'(1)) >> 2);
    localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [XLEN-1:0] mem [DEPTH];
    logic [XLEN-1:0] fifo_data [2];
    logic [1:0]      fifo_err;
    logic            wptr;
    logic            rptr;
    logic [1:0]      count;

    logic            accept;
    logic            pop;
    logic            req_ok;
    logic            wr_ok;
    logic [AW-1:0]   req_idx;
    logic [AW-1:0]   wr_idx;

    // Handshake decode and address qualification
    always_comb begin
        pop       = (count != 2'd0) && rsp_ready;
        req_ready = !rst && ((count < 2'd2) || pop);
        accept    = req_valid && req_ready;
        req_ok    = (req_addr >= BASE_ADDR) && (req_addr <= MAX_ADDR) &&
                    (req_addr[1:0] == 2'b00);
        wr_ok     = wr_en && (wr_addr >= BASE_ADDR) && (wr_addr <= MAX_ADDR) &&
                    (wr_addr[1:0] == 2'b00);
        req_idx   = AW'((req_addr - BASE_ADDR) >> 2);
        wr_idx    = AW'((wr_addr - BASE_ADDR) >> 2);
    end

    // RAM contents are intentionally not reset
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_idx] <= wr_data;
        end
    end

    // The read is captured straight into the FIFO slot, so a same-edge write sees old data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fifo_data[0] <= '0;
            fifo_data[1] <= '0;
            fifo_err     <= 2'b00;
            wptr         <= 1'b0;
            rptr         <= 1'b0;
            count        <= 2'd0;
        end else begin
            if (accept) begin
                fifo_data[wptr] <= req_ok ? mem[req_idx] : '0;
                fifo_err[wptr]  <= !req_ok;
                wptr            <= ~wptr;
            end
            if (pop) begin
                rptr <= ~rptr;
            end
            case ({accept, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    always_comb begin
        rsp_valid = (count != 2'd0);
        rsp_data  = fifo_data[rptr];
        rsp_err   = fifo_err[rptr];
    end

endmodule

// File: tb/tb_imem_responder.sv
// Self-checking bench for imem_responder: queue-based response model, directed
// vectors for the documented scenarios, and a long randomized handshake run.
module tb_imem_responder;

    localparam logic [31:0] BASE = 32'h1000_0000;
    localparam logic [31:0] MAXA = 32'h1000_3FFF;
    localparam logic [31:0] LAST = 32'hCAFE_F00D;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;

    imem_responder dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] data;
        logic        err;
        logic        known;
    } rsp_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] exp_data;
        logic        exp_err;
    } vec_t;

    int unsigned n_cmp = 0;
    int unsigned n_fail = 0;
    int unsigned acc_dut = 0;
    int unsigned pop_dut = 0;

    rsp_t        mq[$];
    logic [31:0] ref_mem [logic [31:0]];
    logic [31:0] popped_q[$];
    logic        last_rdy;
    vec_t        tbl[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit in_range(input logic [31:0] a);
        return (a >= BASE) && (a <= MAXA) && (a % 4 == 0);
    endfunction

    function automatic rsp_t model_rsp(input logic [31:0] a);
        rsp_t r;
        if (!in_range(a)) begin
            r = '{data: 32'h0, err: 1'b1, known: 1'b1};
        end else if (ref_mem.exists(a)) begin
            r = '{data: ref_mem[a], err: 1'b0, known: 1'b1};
        end else begin
            r = '{data: 32'h0, err: 1'b0, known: 1'b0};
        end
        return r;
    endfunction

    // One clock: drive at negedge, compare against the model, advance the model at posedge
    task automatic cycle(input logic rv, input logic [31:0] ra, input logic rr,
                         input logic we, input logic [31:0] wa, input logic [31:0] wd);
        bit   exp_rdy;
        bit   acc;
        bit   pop;
        rsp_t nr;
        @(negedge clk);
        req_valid = rv; req_addr = ra; rsp_ready = rr;
        wr_en = we; wr_addr = wa; wr_data = wd;
        #1;
        exp_rdy  = (mq.size() < 2) || (mq.size() != 0 && rr);
        last_rdy = req_ready;
        chk("req_ready", 32'(req_ready), 32'(exp_rdy));
        chk("rsp_valid", 32'(rsp_valid), 32'(mq.size() != 0));
        if (mq.size() != 0) begin
            chk("rsp_err", 32'(rsp_err), 32'(mq[0].err));
            if (mq[0].known) chk("rsp_data", rsp_data, mq[0].data);
        end
        if (rv && req_ready) acc_dut++;
        if (rsp_valid && rr) begin
            pop_dut++;
            popped_q.push_back(rsp_data);
        end
        acc = rv && exp_rdy;
        pop = rr && (mq.size() != 0);
        nr  = model_rsp(ra);
        @(posedge clk);
        if (pop) mq.delete(0);
        if (acc) mq.push_back(nr);
        if (we && in_range(wa)) ref_mem[wa] = wd;
    endtask

    task automatic req(input logic rv, input logic [31:0] ra, input logic rr);
        cycle(rv, ra, rr, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic wr(input logic [31:0] wa, input logic [31:0] wd);
        cycle(1'b0, 32'h0, 1'b0, 1'b1, wa, wd);
    endtask

    task automatic drain();
        for (int i = 0; i < 4; i++) req(1'b0, 32'h0, 1'b1);
    endtask

    initial begin
        logic [31:0] old_w;
        logic [31:0] a;
        int unsigned k;

        rst = 1'b1; req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("reset rsp_valid", 32'(rsp_valid), 32'h0);
        chk("reset req_ready", 32'(req_ready), 32'h0);
        chk("reset rsp_data",  rsp_data,        32'h0);
        chk("reset rsp_err",   32'(rsp_err),   32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Preload, including writes that must be ignored
        wr(BASE,                 32'h0000_0013);
        wr(BASE + 32'h4,         32'h0010_0093);
        for (int i = 2; i < 64; i++) wr(BASE + 32'(4 * i), $urandom);
        wr(32'h1000_3FFC,        LAST);
        wr(32'h1000_0002,        32'h0000_0BAD);
        wr(32'h1000_4000,        32'h0000_0BAD);

        // Single-request vectors with immediate consumption
        tbl[0] = '{32'h1000_0000, 32'h0000_0013, 1'b0};
        tbl[1] = '{32'h1000_0004, 32'h0010_0093, 1'b0};
        tbl[2] = '{32'h0FFF_FFFC, 32'h0000_0000, 1'b1};
        tbl[3] = '{32'h1000_4000, 32'h0000_0000, 1'b1};
        tbl[4] = '{32'h1000_0002, 32'h0000_0000, 1'b1};
        tbl[5] = '{32'h1000_3FFC, LAST,          1'b0};
        for (int i = 0; i < 6; i++) begin
            req(1'b1, tbl[i].addr, 1'b1);
            #1;
            chk("vec rsp_valid", 32'(rsp_valid), 32'h1);
            chk("vec rsp_data",  rsp_data,        tbl[i].exp_data);
            chk("vec rsp_err",   32'(rsp_err),   32'(tbl[i].exp_err));
        end
        drain();

        // Backpressure: two accepted, third stalls until the pop cycle
        popped_q.delete();
        req(1'b1, 32'h1000_0000, 1'b0);
        chk("bp accept0", 32'(last_rdy), 32'h1);
        req(1'b1, 32'h1000_0004, 1'b0);
        chk("bp accept1", 32'(last_rdy), 32'h1);
        req(1'b1, 32'h1000_0008, 1'b0);
        chk("bp stall2", 32'(last_rdy), 32'h0);
        req(1'b1, 32'h1000_0008, 1'b1);
        chk("bp accept2 on pop", 32'(last_rdy), 32'h1);
        drain();
        chk("bp pop count", 32'(popped_q.size()), 32'd3);
        if (popped_q.size() == 3) begin
            chk("bp order0", popped_q[0], 32'h0000_0013);
            chk("bp order1", popped_q[1], 32'h0010_0093);
            chk("bp order2", popped_q[2], ref_mem[32'h1000_0008]);
        end

        // Same-edge read and write of one word returns the old contents
        old_w = ref_mem[32'h1000_0010];
        cycle(1'b1, 32'h1000_0010, 1'b1, 1'b1, 32'h1000_0010, 32'hDEAD_BEEF);
        #1;
        chk("rw old data", rsp_data, old_w);
        req(1'b1, 32'h1000_0010, 1'b1);
        #1;
        chk("rw new data", rsp_data, 32'hDEAD_BEEF);
        drain();

        // Reset with two responses queued discards them asynchronously
        req(1'b1, 32'h1000_0000, 1'b0);
        req(1'b1, 32'h1000_0004, 1'b0);
        @(negedge clk);
        req_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("mid-reset rsp_valid", 32'(rsp_valid), 32'h0);
        chk("mid-reset req_ready", 32'(req_ready), 32'h0);
        chk("mid-reset rsp_data",  rsp_data,        32'h0);
        mq.delete();
        @(negedge clk);
        rst = 1'b0;
        popped_q.delete();
        req(1'b0, 32'h0, 1'b1);
        chk("post-reset req_ready", 32'(last_rdy), 32'h1);
        req(1'b0, 32'h0, 1'b1);
        chk("no stale rsp", 32'(popped_q.size()), 32'h0);

        // Randomized handshakes with background writes
        acc_dut = 0;
        pop_dut = 0;
        for (int c = 0; c < 10000; c++) begin
            k = $urandom_range(0, 9);
            if (k < 8) begin
                a = BASE + 32'(4 * $urandom_range(0, 63));
            end else begin
                case ($urandom_range(0, 3))
                    0:       a = BASE - 32'(4 * $urandom_range(1, 8));
                    1:       a = 32'h1000_4000 + 32'(4 * $urandom_range(0, 8));
                    2:       a = BASE + 32'(4 * $urandom_range(0, 63)) + 32'($urandom_range(1, 3));
                    default: a = 32'h1000_3FFC;
                endcase
            end
            cycle($urandom_range(0, 99) < 60, a, $urandom_range(0, 99) < 55,
                  $urandom_range(0, 9) == 0, BASE + 32'(4 * $urandom_range(0, 63)), $urandom);
        end
        drain();
        chk("rand rsp count", pop_dut, acc_dut);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/imem_responder.md
IMEM_RESPONDER -- requirements
Module: imem_responder

Interface
REQ-001 Parameter BASE_ADDR, default 32'h1000_0000, first byte address served.
REQ-002 Parameter MAX_ADDR, default 32'h1000_3FFF, last byte address served; depth = (MAX_ADDR-BASE_ADDR+1)/4 words (4096 by default).
REQ-003 Parameter XLEN, default 32, address and data width.
REQ-004 clk  input  1  single core clock; all state changes on rising edge.
REQ-005 rst  input  1  reset, asynchronous assert, active-high.
REQ-006 req_valid  input  1  fetch stage presents an address.
REQ-007 req_ready  output  1  responder accepts the address this cycle.
REQ-008 req_addr  input  XLEN  byte address of the instruction.
REQ-009 rsp_valid  output  1  response word available.
REQ-010 rsp_ready  input  1  fetch stage consumes the response.
REQ-011 rsp_data  output  XLEN  instruction word.
REQ-012 rsp_err  output  1  access fault for this response.
REQ-013 wr_en  input  1  preload write strobe (boot/test loader).
REQ-014 wr_addr  input  XLEN  preload byte address.
REQ-015 wr_data  input  XLEN  preload word.

Function
REQ-016 A request SHALL be accepted on a rising edge where req_valid=1 and req_ready=1.
REQ-017 The responder SHALL hold at most 2 outstanding responses (in-flight read plus queued); req_ready=1 iff outstanding count <2, or count=2 with a response popped this cycle (rsp_valid & rsp_ready).
REQ-018 An accepted in-range request SHALL read word index (req_addr-BASE_ADDR)>>2 from synchronous RAM; data SHALL be presentable on rsp_* no earlier than the cycle after acceptance (1-cycle minimum latency).
REQ-019 Responses SHALL be returned strictly in request order through a 2-entry FIFO; rsp_valid=1 iff FIFO non-empty.
REQ-020 rsp_data/rsp_err SHALL remain stable while rsp_valid=1 and rsp_ready=0.
REQ-021 A response SHALL pop on a rising edge where rsp_valid=1 and rsp_ready=1.
REQ-022 Simultaneous accept and pop SHALL leave the outstanding count unchanged; the count SHALL never exceed 2 or underflow below 0.
REQ-023 Request with req_addr<BASE_ADDR, req_addr>MAX_ADDR, or req_addr[1:0]!=0 SHALL be accepted normally and yield rsp_err=1, rsp_data=0, with no RAM access.
REQ-024 In-range responses SHALL carry rsp_err=0.
REQ-025 wr_en=1 with aligned in-range wr_addr SHALL write wr_data on that edge; out-of-range or misaligned writes SHALL be ignored.
REQ-026 A read and write to the same word on the same edge SHALL return the old (pre-write) data.
REQ-027 Writes SHALL be independent of request/response handshakes and never stall req_ready.
REQ-028 RAM contents SHALL NOT be initialised by reset; unwritten words return undefined data with rsp_err=0.

Reset
REQ-029 While rst=1: rsp_valid=0, rsp_err=0, rsp_data=0, req_ready=0, outstanding count=0, FIFO pointers=0.
REQ-030 Reset asserted mid-operation SHALL discard all in-flight and queued responses; no response SHALL appear for pre-reset requests.
REQ-031 req_ready SHALL be 1 from the first rising edge after rst deasserts (count=0).

Verification
REQ-032 Preload word 0 = 32'h0000_0013, word 1 = 32'h0010_0093; request 0x1000_0000 with rsp_ready=1 -> next cycle rsp_valid=1, rsp_data=32'h0000_0013, rsp_err=0.
REQ-033 Back-to-back requests 0x1000_0000, 0x1000_0004, 0x1000_0008 with rsp_ready=0 -> first two accepted, req_ready=0 on third; raise rsp_ready -> responses in order, third accepted in the pop cycle.
REQ-034 Request 0x0FFF_FFFC, 0x1000_4000, 0x1000_0002 -> each rsp_err=1, rsp_data=0; in-range request 0x1000_3FFC afterwards -> rsp_err=0, last RAM word.
REQ-035 Same-edge write 32'hDEAD_BEEF and read of 0x1000_0010 -> response shows old word; repeat read -> 32'hDEAD_BEEF.
REQ-036 Two responses queued, assert rst one cycle -> rsp_valid=0 immediately (asynchronous), after release req_ready=1 and no stale response appears.
REQ-037 Random req_valid/rsp_ready stimulus over 10,000 cycles -> response count equals accepted count, order and data match a reference model, rsp_* stable under stall.
